// File: rtl/core_pipe_ctrl.sv
// rtl/core_pipe_ctrl.sv - RV32I pipeline sequencer: stall/flush control, PC redirect, debug halt
module core_pipe_ctrl #(
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_addr_in,
  input  logic [4:0]  id_rs2_addr_in,
  input  logic        id_rs1_re_in,
  input  logic        id_rs2_re_in,
  input  logic [4:0]  ex_rd_addr_in,
  input  logic        ex_is_load_in,
  input  logic        ex_busy_in,
  input  logic        jump_flag_in,
  input  logic [31:0] jump_addr_in,
  input  logic        halt_req_in,
  output logic        halt_ack_out,
  output logic [2:0]  stall_out,
  output logic [1:0]  flush_out,
  output logic        jump_flag_out,
  output logic [31:0] jump_addr_out
);

  localparam int CW = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            load_use;

  // Load in EX whose destination is read by the instruction in ID; x0 never hazards
  always_comb begin
    load_use = ex_is_load_in & (ex_rd_addr_in != 5'd0) &
               ((id_rs1_re_in & (id_rs1_addr_in == ex_rd_addr_in)) |
                (id_rs2_re_in & (id_rs2_addr_in == ex_rd_addr_in)));
  end

  // Same-cycle stall/flush/redirect decode from current state and inputs
  always_comb begin
    stall_out     = 3'b000;
    flush_out     = 2'b00;
    jump_flag_out = 1'b0;
    jump_addr_out = 32'd0;
    if (rst) begin
      flush_out = 2'b11;
    end else begin
      case (state)
        RUN: begin
          if (ex_busy_in) begin
            stall_out = 3'b111;
          end else if (jump_flag_in) begin
            jump_flag_out = 1'b1;
            jump_addr_out = jump_addr_in;
            flush_out     = 2'b11;
          end else if (load_use || halt_req_in) begin
            // Hold PC and IF/ID, send one bubble into EX
            stall_out = 3'b011;
            flush_out = 2'b10;
          end
        end
        FLUSH: begin
          flush_out = 2'b11;
        end
        HALT: begin
          stall_out = 3'b011;
          flush_out = 2'b10;
        end
        default: begin
          flush_out = 2'b11;
        end
      endcase
    end
  end

  // Sequencer state, flush countdown and registered halt acknowledge
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      cnt          <= '0;
      halt_ack_out <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (ex_busy_in) begin
            state <= RUN;
          end else if (jump_flag_in) begin
            if (FLUSH_CYCLES > 1) begin
              state <= FLUSH;
              cnt   <= CW'(FLUSH_CYCLES - 1);
            end
          end else if (load_use) begin
            state <= RUN;
          end else if (halt_req_in) begin
            state        <= HALT;
            halt_ack_out <= 1'b1;
          end
        end
        FLUSH: begin
          if (cnt <= CW'(1)) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        HALT: begin
          if (!halt_req_in) begin
            state        <= RUN;
            halt_ack_out <= 1'b0;
          end
        end
        default: begin
          state        <= RUN;
          cnt          <= '0;
          halt_ack_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_pipe_ctrl.sv
// tb/tb_core_pipe_ctrl.sv - directed vector bench for core_pipe_ctrl
module tb_core_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1_addr_in, id_rs2_addr_in, ex_rd_addr_in;
  logic        id_rs1_re_in, id_rs2_re_in, ex_is_load_in, ex_busy_in;
  logic        jump_flag_in, halt_req_in;
  logic [31:0] jump_addr_in;
  logic        halt_ack_out, jump_flag_out;
  logic [2:0]  stall_out;
  logic [1:0]  flush_out;
  logic [31:0] jump_addr_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  core_pipe_ctrl #(.FLUSH_CYCLES(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs1_addr_in (id_rs1_addr_in),
    .id_rs2_addr_in (id_rs2_addr_in),
    .id_rs1_re_in   (id_rs1_re_in),
    .id_rs2_re_in   (id_rs2_re_in),
    .ex_rd_addr_in  (ex_rd_addr_in),
    .ex_is_load_in  (ex_is_load_in),
    .ex_busy_in     (ex_busy_in),
    .jump_flag_in   (jump_flag_in),
    .jump_addr_in   (jump_addr_in),
    .halt_req_in    (halt_req_in),
    .halt_ack_out   (halt_ack_out),
    .stall_out      (stall_out),
    .flush_out      (flush_out),
    .jump_flag_out  (jump_flag_out),
    .jump_addr_out  (jump_addr_out)
  );

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic        re1, re2, load, busy, jump, halt;
    logic [31:0] jaddr;
    logic [2:0]  stall;
    logic [1:0]  flush;
    logic        jf;
    logic [31:0] ja;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] s, input logic [1:0] f,
                         input logic jf, input logic ack);
    check({tag, ".stall"}, 32'(stall_out), 32'(s));
    check({tag, ".flush"}, 32'(flush_out), 32'(f));
    check({tag, ".jf"},    32'(jump_flag_out), 32'(jf));
    check({tag, ".ack"},   32'(halt_ack_out), 32'(ack));
  endtask

  task automatic idle_inputs();
    id_rs1_addr_in = 0; id_rs2_addr_in = 0; ex_rd_addr_in = 0;
    id_rs1_re_in = 0; id_rs2_re_in = 0; ex_is_load_in = 0; ex_busy_in = 0;
    jump_flag_in = 0; jump_addr_in = 0; halt_req_in = 0;
  endtask

  // advance one clock, land 1 time unit after the falling edge
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic [4:0] rs1, logic re1, logic [4:0] rs2, logic re2,
                              logic [4:0] rd, logic load, logic busy, logic jump,
                              logic [31:0] jaddr, logic halt,
                              logic [2:0] stall, logic [1:0] flush, logic jf, logic [31:0] ja);
    vec_t v;
    v.rs1 = rs1; v.re1 = re1; v.rs2 = rs2; v.re2 = re2; v.rd = rd; v.load = load;
    v.busy = busy; v.jump = jump; v.jaddr = jaddr; v.halt = halt;
    v.stall = stall; v.flush = flush; v.jf = jf; v.ja = ja;
    return v;
  endfunction

  initial begin
    // rs1 re1 rs2 re2 rd load busy jump jaddr halt -> stall flush jf ja
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0,          3'b000, 2'b00, 0, 32'h0);
    vecs[1]  = mk(0, 0, 5, 1, 5, 1, 0, 0, 32'h0, 0,          3'b011, 2'b10, 0, 32'h0);
    vecs[2]  = mk(0, 0, 5, 1, 0, 1, 0, 0, 32'h0, 0,          3'b000, 2'b00, 0, 32'h0);
    vecs[3]  = mk(0, 1, 0, 1, 0, 1, 0, 0, 32'h0, 0,          3'b000, 2'b00, 0, 32'h0);
    vecs[4]  = mk(7, 1, 3, 1, 7, 1, 0, 0, 32'h0, 0,          3'b011, 2'b10, 0, 32'h0);
    vecs[5]  = mk(7, 0, 3, 1, 7, 1, 0, 0, 32'h0, 0,          3'b000, 2'b00, 0, 32'h0);
    vecs[6]  = mk(7, 1, 7, 1, 7, 0, 0, 0, 32'h0, 0,          3'b000, 2'b00, 0, 32'h0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 0,          3'b111, 2'b00, 0, 32'h0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 32'hDEAD_BEE0, 0,  3'b111, 2'b00, 0, 32'h0);
    vecs[9]  = mk(9, 1, 0, 0, 9, 1, 0, 0, 32'h0, 1,          3'b011, 2'b10, 0, 32'h0);
    vecs[10] = mk(9, 1, 0, 0, 9, 1, 1, 0, 32'h0, 0,          3'b111, 2'b00, 0, 32'h0);

    idle_inputs();
    rst = 1'b1;
    jump_flag_in = 1'b1;
    jump_addr_in = 32'h0000_0100;

    // reset held two cycles with a jump pending
    #1;
    chk_out("rst0", 3'b000, 2'b11, 0, 0);
    check("rst0.ja", jump_addr_out, 32'h0);
    next_cycle();
    chk_out("rst1", 3'b000, 2'b11, 0, 0);
    check("rst1.ja", jump_addr_out, 32'h0);
    idle_inputs();
    rst = 1'b0;
    #1;
    chk_out("rel", 3'b000, 2'b00, 0, 0);

    // combinational vectors that keep the state in RUN
    for (int i = 0; i < 11; i++) begin
      next_cycle();
      id_rs1_addr_in = vecs[i].rs1; id_rs1_re_in = vecs[i].re1;
      id_rs2_addr_in = vecs[i].rs2; id_rs2_re_in = vecs[i].re2;
      ex_rd_addr_in = vecs[i].rd; ex_is_load_in = vecs[i].load;
      ex_busy_in = vecs[i].busy; jump_flag_in = vecs[i].jump;
      jump_addr_in = vecs[i].jaddr; halt_req_in = vecs[i].halt;
      #1;
      chk_out($sformatf("vec%0d", i), vecs[i].stall, vecs[i].flush, vecs[i].jf, 1'b0);
      check($sformatf("vec%0d.ja", i), jump_addr_out, vecs[i].ja);
    end
    next_cycle();
    idle_inputs();
    #1;
    chk_out("post_vec", 3'b000, 2'b00, 0, 0);

    // busy holds off the jump, then redirect and two FLUSH cycles
    next_cycle();
    ex_busy_in = 1; jump_flag_in = 1; jump_addr_in = 32'h0000_0100;
    #1;
    chk_out("busyjmp", 3'b111, 2'b00, 0, 0);
    next_cycle();
    ex_busy_in = 0;
    #1;
    chk_out("jmp", 3'b000, 2'b11, 1, 0);
    check("jmp.ja", jump_addr_out, 32'h0000_0100);
    next_cycle();
    jump_addr_in = 32'h0000_0200;
    ex_is_load_in = 1; ex_rd_addr_in = 4; id_rs1_re_in = 1; id_rs1_addr_in = 4;
    #1;
    chk_out("fl1", 3'b000, 2'b11, 0, 0);
    check("fl1.ja", jump_addr_out, 32'h0);
    next_cycle();
    idle_inputs();
    #1;
    chk_out("fl2", 3'b000, 2'b11, 0, 0);
    next_cycle();
    chk_out("fl_end", 3'b000, 2'b00, 0, 0);

    // halt entry, ignored events in HALT, release
    next_cycle();
    halt_req_in = 1;
    #1;
    chk_out("h0", 3'b011, 2'b10, 0, 0);
    next_cycle();
    chk_out("h1", 3'b011, 2'b10, 0, 1);
    jump_flag_in = 1; ex_busy_in = 1; jump_addr_in = 32'h0000_0300;
    #1;
    chk_out("h1ign", 3'b011, 2'b10, 0, 1);
    next_cycle();
    jump_flag_in = 0; ex_busy_in = 0; halt_req_in = 0;
    #1;
    chk_out("h2", 3'b011, 2'b10, 0, 1);
    next_cycle();
    chk_out("h3", 3'b000, 2'b00, 0, 0);

    // halt requested during FLUSH is deferred until RUN
    next_cycle();
    jump_flag_in = 1; jump_addr_in = 32'h0000_0400;
    #1;
    chk_out("d0", 3'b000, 2'b11, 1, 0);
    next_cycle();
    jump_flag_in = 0; halt_req_in = 1;
    #1;
    chk_out("d1", 3'b000, 2'b11, 0, 0);
    next_cycle();
    chk_out("d2", 3'b000, 2'b11, 0, 0);
    next_cycle();
    chk_out("d3", 3'b011, 2'b10, 0, 0);
    next_cycle();
    chk_out("d4", 3'b011, 2'b10, 0, 1);
    halt_req_in = 0;
    next_cycle();
    chk_out("d5", 3'b000, 2'b00, 0, 0);

    // reset mid-FLUSH aborts back to RUN
    next_cycle();
    jump_flag_in = 1; jump_addr_in = 32'h0000_0500;
    next_cycle();
    jump_flag_in = 0;
    #1;
    chk_out("r0", 3'b000, 2'b11, 0, 0);
    rst = 1;
    next_cycle();
    rst = 0;
    #1;
    chk_out("r1", 3'b000, 2'b00, 0, 0);

    // reset while halted clears the acknowledge
    next_cycle();
    halt_req_in = 1;
    next_cycle();
    chk_out("rh0", 3'b011, 2'b10, 0, 1);
    rst = 1;
    next_cycle();
    rst = 0; halt_req_in = 0;
    #1;
    chk_out("rh1", 3'b000, 2'b00, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
